// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter. It latches a pattern, a repeat count and an
// inter-frame gap on start, then shifts the pattern out MSB-first, one bit per
// clock. Frames can run back-to-back (gap 0) or be separated by gap cycles.
// Every output comes straight from a flop.
module seq_pattern_tx #(
    parameter int unsigned PAT_W   = 4,
    parameter int unsigned GAP_W   = 4,
    parameter logic        GAP_LVL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [7:0]       reps,
    input  logic [GAP_W-1:0] gap,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [7:0]       frames_sent
);

    localparam int unsigned      IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [7:0]       reps_q, reps_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             bit_q, bit_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       frames_q, frames_d;
    logic [IDX_W-1:0] idx_dec;

    assign idx_dec = idx_q - 1'b1;

    // State, shadow registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            pat_q    <= '0;
            reps_q   <= '0;
            gap_q    <= '0;
            gcnt_q   <= '0;
            idx_q    <= '0;
            bit_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            reps_q   <= reps_d;
            gap_q    <= gap_d;
            gcnt_q   <= gcnt_d;
            idx_q    <= idx_d;
            bit_q    <= bit_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            frames_q <= frames_d;
        end
    end

    // Next-state and next-output logic; done is a single-cycle pulse by default.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        reps_d   = reps_q;
        gap_d    = gap_q;
        gcnt_d   = gcnt_q;
        idx_d    = idx_q;
        bit_d    = bit_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        frames_d = frames_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pat_d    = pattern;
                    reps_d   = reps;
                    gap_d    = gap;
                    frames_d = '0;
                    if (reps != 8'd0) begin
                        idx_d   = IDX_MSB;
                        bit_d   = pattern[PAT_W-1];
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        state_d = StSend;
                    end else begin
                        // Empty job: report completion without sending anything.
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StSend: begin
                if (abort) begin
                    bit_d   = 1'b0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (idx_q != '0) begin
                    idx_d = idx_dec;
                    bit_d = pat_q[idx_dec];
                end else begin
                    // Bit 0 has been on the line for a cycle: the frame is complete.
                    frames_d = (frames_q == 8'hFF) ? frames_q : frames_q + 8'd1;
                    reps_d   = reps_q - 8'd1;
                    if (reps_q > 8'd1) begin
                        if (gap_q == '0) begin
                            idx_d = IDX_MSB;
                            bit_d = pat_q[PAT_W-1];
                        end else begin
                            gcnt_d  = gap_q;
                            bit_d   = GAP_LVL;
                            valid_d = 1'b0;
                            state_d = StGap;
                        end
                    end else begin
                        bit_d   = 1'b0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StGap: begin
                if (abort) begin
                    bit_d   = 1'b0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (gcnt_q == GAP_W'(1)) begin
                    idx_d   = IDX_MSB;
                    bit_d   = pat_q[PAT_W-1];
                    valid_d = 1'b1;
                    state_d = StSend;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bit_out     = bit_q;
    assign bit_valid   = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: a 4-bit instance covers the main scenarios,
// and an 8-bit instance covers the pattern-width parameter.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort;
    logic [3:0] pattern;
    logic [7:0] reps;
    logic [3:0] gap;
    logic       bit_out, bit_valid, busy, done;
    logic [7:0] frames_sent;

    logic       start8, abort8;
    logic [7:0] pattern8;
    logic [7:0] reps8;
    logic [3:0] gap8;
    logic       bo8, bv8, busy8, done8;
    logic [7:0] fs8;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_bits;
    logic [15:0] exp_valid;
    logic [7:0]  exp_pat8;

    always #5 clk = ~clk;

    seq_pattern_tx #(.PAT_W(4), .GAP_W(4), .GAP_LVL(1'b0)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern(pattern),
        .reps(reps), .gap(gap), .bit_out(bit_out), .bit_valid(bit_valid),
        .busy(busy), .done(done), .frames_sent(frames_sent)
    );

    seq_pattern_tx #(.PAT_W(8), .GAP_W(4), .GAP_LVL(1'b0)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .abort(abort8), .pattern(pattern8),
        .reps(reps8), .gap(gap8), .bit_out(bo8), .bit_valid(bv8),
        .busy(busy8), .done(done8), .frames_sent(fs8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; pattern = '0; reps = '0; gap = '0;
        start8 = 1'b0; abort8 = 1'b0; pattern8 = '0; reps8 = '0; gap8 = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_bit", bit_out, 1'b0);
        chk("rst_valid", bit_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk8("rst_frames", frames_sent, 8'd0);
        chk("rst_busy8", busy8, 1'b0);

        // 1010 x2, gap 0: eight back-to-back bits, done on the ninth cycle.
        pattern = 4'b1010; reps = 8'd2; gap = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("b2b_bit", bit_out, pattern[3 - (k % 4)]);
            chk("b2b_valid", bit_valid, 1'b1);
            chk("b2b_busy", busy, 1'b1);
            chk("b2b_nodone", done, 1'b0);
            if (k == 4) chk8("b2b_frames1", frames_sent, 8'd1);
            step();
        end
        chk("b2b_done", done, 1'b1);
        chk("b2b_busy_end", busy, 1'b0);
        chk("b2b_valid_end", bit_valid, 1'b0);
        chk8("b2b_frames", frames_sent, 8'd2);
        step();
        chk("b2b_done_clr", done, 1'b0);

        // 1010 x3, gap 2: 1010 00 1010 00 1010, done after edge N+16.
        pattern = 4'b1010; reps = 8'd3; gap = 4'd2; start = 1'b1;
        exp_bits  = 16'b1010_00_1010_00_1010;
        exp_valid = 16'b1111_00_1111_00_1111;
        step();
        start = 1'b0;
        pattern = 4'b0000; reps = 8'd9; gap = 4'd0;  // must not affect the job
        for (int k = 0; k < 16; k++) begin
            chk("gap_bit", bit_out, exp_bits[15 - k]);
            chk("gap_valid", bit_valid, exp_valid[15 - k]);
            chk("gap_busy", busy, 1'b1);
            if (k == 4)  chk8("gap_frames1", frames_sent, 8'd1);
            if (k == 10) chk8("gap_frames2", frames_sent, 8'd2);
            step();
        end
        chk("gap_done", done, 1'b1);
        chk8("gap_frames3", frames_sent, 8'd3);
        step();
        chk("gap_done_clr", done, 1'b0);

        // reps=0: done pulses once, nothing sent, frames_sent clears.
        reps = 8'd0; pattern = 4'b1111; start = 1'b1;
        step();
        start = 1'b0;
        chk("r0_done", done, 1'b1);
        chk("r0_valid", bit_valid, 1'b0);
        chk("r0_busy", busy, 1'b0);
        chk8("r0_frames", frames_sent, 8'd0);
        step();
        chk("r0_done_clr", done, 1'b0);
        chk("r0_valid2", bit_valid, 1'b0);
        step();

        // Start while busy is ignored: 0100 is sent, not 1111.
        pattern = 4'b0100; reps = 8'd1; gap = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("sb_bit0", bit_out, 1'b0);
        step();
        chk("sb_bit1", bit_out, 1'b1);
        pattern = 4'b1111; reps = 8'd5; start = 1'b1;
        step();
        start = 1'b0;
        chk("sb_bit2", bit_out, 1'b0);
        step();
        chk("sb_bit3", bit_out, 1'b0);
        chk("sb_nodone", done, 1'b0);
        step();
        chk("sb_done", done, 1'b1);
        chk8("sb_frames", frames_sent, 8'd1);
        step();
        chk("sb_done_once", done, 1'b0);
        chk("sb_idle", busy, 1'b0);
        step();

        // Abort on the 2nd bit of the second frame: 1100 x4, gap 1.
        pattern = 4'b1100; reps = 8'd4; gap = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("ab_bit_before", bit_out, 1'b1);
        chk8("ab_frames_before", frames_sent, 8'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_busy", busy, 1'b0);
        chk("ab_bit", bit_out, 1'b0);
        chk("ab_valid", bit_valid, 1'b0);
        chk("ab_nodone", done, 1'b0);
        chk8("ab_frames", frames_sent, 8'd1);
        step();
        chk("ab_nodone2", done, 1'b0);
        chk("ab_idle", busy, 1'b0);

        // Reset mid-SEND wins over start; outputs clear on the first rst edge.
        pattern = 4'b1010; reps = 8'd3; gap = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("mr_bit", bit_out, 1'b0);
        chk("mr_valid", bit_valid, 1'b0);
        chk("mr_busy", busy, 1'b0);
        chk8("mr_frames", frames_sent, 8'd0);
        step(); step();
        rst = 1'b0;
        step();
        chk("mr_idle_busy", busy, 1'b0);
        chk("mr_idle_valid", bit_valid, 1'b0);
        step();
        chk("mr_idle_busy2", busy, 1'b0);

        // 8-bit instance: A5 once, done after edge N+8.
        pattern8 = 8'hA5; reps8 = 8'd1; gap8 = 4'd0; start8 = 1'b1;
        exp_pat8 = 8'hA5;
        step();
        start8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("w8_bit", bo8, exp_pat8[7 - k]);
            chk("w8_valid", bv8, 1'b1);
            step();
        end
        chk("w8_done", done8, 1'b1);
        chk("w8_busy", busy8, 1'b0);
        chk8("w8_frames", fs8, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
